// File: rtl/pwm_breath_pkg.sv
// pwm_breath_pkg: shared types and width helpers for the breathing PWM.
// Holds the sequencer state enum and constant-function width calculators.
package pwm_breath_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_TOP,
        S_FALL,
        S_BOTTOM
    } state_e;

    // Bits needed to hold a duty value in 0..cycle.
    function automatic int duty_w(input int cycle);
        return $clog2(cycle + 1);
    endfunction

    // Bits needed for a hold counter that never exceeds max(...)-1.
    function automatic int hold_w(
        input int hp,
        input int th,
        input int bh
    );
        int m;
        m = hp;
        if (th > m) m = th;
        if (bh > m) m = bh;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pwm_breath_gen.sv
// pwm_breath_gen: free-running PWM period counter and registered comparator.
// Ports: clk, rst_n (async low), duty in; pwm (registered), period_tick out.
module pwm_breath_gen
    import pwm_breath_pkg::*;
#(
    parameter int CYCLE = 100,
    parameter int W     = duty_w(CYCLE)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] duty,
    output logic         pwm,
    output logic         period_tick
);

    localparam int            CW   = $clog2(CYCLE);
    localparam logic [CW-1:0] LAST = CW'(CYCLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pwm_q, pwm_d;

    assign period_tick = (cnt_q == LAST);
    assign cnt_d = period_tick ? '0 : cnt_q + CW'(1);
    assign pwm_d = (W'(cnt_q) < duty);
    assign pwm   = pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: breathing sequencer (IDLE/RISE/TOP/FALL/BOTTOM) driving
// pwm_breath_gen. Ports: clk, rst_n (async low), en in; pwm, duty, busy,
// period_tick out. Optional macro PWM_BREATH_COUNT_EN adds breath_cnt[15:0].
module pwm_breath_ctrl
    import pwm_breath_pkg::*;
#(
    parameter int CYCLE        = 100,
    parameter int STEP         = 1,
    parameter int HOLD_PERIODS = 4,
    parameter int TOP_HOLD     = 8,
    parameter int BOT_HOLD     = 8,
    localparam int W           = duty_w(CYCLE)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic         pwm,
    output logic [W-1:0] duty,
    output logic         busy,
    output logic         period_tick
`ifdef PWM_BREATH_COUNT_EN
    ,
    output logic [15:0]  breath_cnt
`endif
);

    localparam int HW = hold_w(HOLD_PERIODS, TOP_HOLD, BOT_HOLD);

    localparam logic [W:0]    CYC_X = (W+1)'(CYCLE);
    localparam logic [W-1:0]  CYC_D = W'(CYCLE);
    localparam logic [W-1:0]  STP_D = W'(STEP);
    localparam logic [HW-1:0] HP_LAST = HW'(HOLD_PERIODS - 1);
    localparam logic [HW-1:0] TOP_LAST =
        (TOP_HOLD == 0) ? '0 : HW'(TOP_HOLD - 1);
    localparam logic [HW-1:0] BOT_LAST =
        (BOT_HOLD == 0) ? '0 : HW'(BOT_HOLD - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  duty_q, duty_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [W:0]    sum;
    logic          tick;
    logic          top_done, bot_done;

    pwm_breath_gen #(
        .CYCLE (CYCLE),
        .W     (W)
    ) u_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .duty        (duty_q),
        .pwm         (pwm),
        .period_tick (tick)
    );

    // One extra bit so the ramp can overshoot CYCLE before clamping.
    assign sum      = {1'b0, duty_q} + {1'b0, STP_D};
    assign top_done = (TOP_HOLD == 0) || (hold_q >= TOP_LAST);
    assign bot_done = (BOT_HOLD == 0) || (hold_q >= BOT_LAST);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (tick) begin
            hold_d = hold_q + HW'(1);
            unique case (state_q)
                S_IDLE: begin
                    duty_d = '0;
                    if (en) state_d = S_RISE;
                end
                S_RISE: begin
                    if (!en) begin
                        state_d = S_FALL;
                    end else if (hold_q == HP_LAST) begin
                        hold_d = '0;
                        if (sum >= CYC_X) begin
                            duty_d  = CYC_D;
                            state_d = S_TOP;
                        end else begin
                            duty_d = sum[W-1:0];
                        end
                    end
                end
                S_TOP: begin
                    if (!en || top_done) state_d = S_FALL;
                end
                S_FALL: begin
                    // en is ignored here so the fade-out always completes.
                    if (hold_q == HP_LAST) begin
                        hold_d = '0;
                        if (duty_q <= STP_D) begin
                            duty_d  = '0;
                            state_d = S_BOTTOM;
                        end else begin
                            duty_d = duty_q - STP_D;
                        end
                    end
                end
                S_BOTTOM: begin
                    if (!en) state_d = S_IDLE;
                    else if (bot_done) state_d = S_RISE;
                end
                default: state_d = S_IDLE;
            endcase
            if (state_d != state_q || state_q == S_IDLE) hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    assign duty        = duty_q;
    assign busy        = (state_q != S_IDLE);
    assign period_tick = tick;

`ifdef PWM_BREATH_COUNT_EN
    logic [15:0] breath_cnt_q;
    logic        brk;

    assign brk = tick && (state_q == S_FALL) && (state_d == S_BOTTOM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            breath_cnt_q <= '0;
        end else if (brk) begin
            breath_cnt_q <= breath_cnt_q + 16'd1;
        end
    end

    assign breath_cnt = breath_cnt_q;
`endif

endmodule

// File: doc/pwm_breath_ctrl.md
# pwm_breath_ctrl

Breathing-effect sequencer for the board's PWM LED path. It owns a PWM period counter and comparator, and ramps the duty value up and down in fixed steps at period boundaries. The ramp produces a smooth fade-in, hold, fade-out, hold cycle for as long as `en` is high. It sits between the user-control logic and an LED pin, replacing static `duty`/`cycle` parameter settings with run-time sequencing.

## Interface
- `CYCLE`, default 100: PWM period in clk cycles; must be ≥2.
- `STEP`, default 1: duty increment/decrement per ramp step; 1 ≤ STEP ≤ CYCLE.
- `HOLD_PERIODS`, default 4: PWM periods per ramp step; must be ≥1.
- `TOP_HOLD`, default 8: periods held at full duty; 0 is allowed.
- `BOT_HOLD`, default 8: periods held at zero duty; 0 is allowed.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: level request to breathe. Sampled only at period boundaries.
- `pwm` output 1: registered PWM output.
- `duty` output W: current duty, 0..CYCLE, where W = clog2(CYCLE+1).
- `busy` output 1: high whenever the state is not IDLE.
- `period_tick` output 1: one-cycle pulse on the last clk of each PWM period.

## Operation
- Free-running counter `cnt` runs 0..CYCLE-1 and wraps to 0. It runs in every state, including IDLE.
- `period_tick` = (cnt == CYCLE-1).
- `pwm` <= (cnt < duty), registered, so it lags `cnt` by 1 clk.
  - duty=0 gives a constant low output.
  - duty=CYCLE gives a constant high output.
- `duty` and the state change only on clocks where `period_tick` is high. The new duty therefore first applies at cnt=0, so no glitch or partial period ever occurs.
- `hold_cnt` counts ticks inside a state and clears on every state change.
- State behaviour, evaluated on each tick:
  - IDLE: duty=0. If en=1, go to RISE.
  - RISE:
    - If en=0, go to FALL immediately.
    - Otherwise, when hold_cnt == HOLD_PERIODS-1, set duty <= min(duty+STEP, CYCLE). If the result equals CYCLE, go to TOP.
  - TOP:
    - If en=0, go to FALL.
    - Otherwise, when hold_cnt ≥ TOP_HOLD-1 (or immediately if TOP_HOLD=0), go to FALL.
  - FALL: when hold_cnt == HOLD_PERIODS-1:
    - If duty ≤ STEP, set duty <= 0 and go to BOTTOM.
    - Otherwise, duty <= duty-STEP.
    - `en` is ignored in FALL, so the fade-out always completes.
  - BOTTOM: when hold_cnt ≥ BOT_HOLD-1 (or immediately if BOT_HOLD=0), go to RISE if en=1, else IDLE. If en=0 on any BOTTOM tick, go to IDLE immediately.
- Arithmetic:
  - Addition is done at W+1 bits, then saturated to CYCLE.
  - Subtraction is guarded by the compare above, so it never underflows.

## Timing
- Reset values: pwm=0, duty=0, busy=0, period_tick=0, cnt=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-ramp forces all of the above asynchronously. There is no fade-out.
- Start latency: from en=1 to busy=1 is at most CYCLE clks (the next tick). The first duty change follows HOLD_PERIODS ticks later.
- `busy` rises and falls on the tick edge.
- `duty` → `pwm` latency: the new duty is visible on `pwm` at the clk after cnt returns to 0.
- If en deasserts and reasserts between ticks, the intermediate value is not seen. Only the value at each tick matters.

## Configuration
- Macro: `PWM_BREATH_COUNT_EN`.
- Defined: adds output `breath_cnt` [15:0], reset 0.
  - Increments on each FALL→BOTTOM transition.
  - Wraps from 0xFFFF to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `pwm_breath_pkg` contains:
  - the state enum (IDLE, RISE, TOP, FALL, BOTTOM);
  - a width helper function for clog2(CYCLE+1);
  - a hold-counter width helper covering max(HOLD_PERIODS, TOP_HOLD, BOT_HOLD).
- Sub-module `pwm_breath_gen`: holds `cnt`, the `period_tick` output and the registered compare. Parameter CYCLE; input `duty`; outputs `pwm` and `period_tick`.
- The top level holds the FSM, the duty register and the hold counter.

## Test plan
Unless a line says otherwise, use CYCLE=10, STEP=2, HOLD_PERIODS=1, TOP_HOLD=2, BOT_HOLD=1.
- Reset release with en=0 → pwm=0, duty=0, busy=0 indefinitely. period_tick pulses every 10 clks at cnt=9.
- en=1 held:
  - duty sequence per period is 0,2,4,6,8,10, then two periods at 10, then 8,6,4,2,0, then one period at 0, then repeats.
  - The high-count of pwm in each period equals duty exactly.
- en drops during RISE at duty=6 → next tick goes to FALL. Duty sequence is 4,2,0, then IDLE; busy falls on the tick entering IDLE.
- With STEP=3, the ramp saturates: duty 0,3,6,9,10 (clamped), then FALL 7,4,1,0, with no underflow.
- Assert rst_n mid-TOP → pwm and duty go to 0 immediately, without waiting for a clock edge. After release with en=1, restart begins at the next tick.
- With `PWM_BREATH_COUNT_EN` defined: 3 full breaths give breath_cnt=3. Preloading the counter near 0xFFFF through force shows it wrap to 0.
